// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// Instruction fetch sequencer: steers the external PC register, issues imem fetches and hands fetched words to decode.
// Define TRAP_EN_EN to add the trap redirect input and the trap_epc capture register.
module fetch_sequencer #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
`ifdef TRAP_EN_EN
  input  logic        trap,
  output logic [31:0] trap_epc,
`endif
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  state_t      state;
  state_t      state_next;
  logic        kill;
  logic [31:0] kill_target;
  logic        trap_hit;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        handshake;
  logic        capture;
  logic        clear_valid;
  logic        set_kill;
  logic        clr_kill;

`ifdef TRAP_EN_EN
  assign trap_hit = trap;
`else
  assign trap_hit = 1'b0;
`endif

  // Trap takes priority over a same-cycle branch; branch targets are forced word-aligned.
  assign redirect        = trap_hit | br_taken;
  assign redirect_target = trap_hit ? TRAP_VEC : (br_target & 32'hFFFF_FFFC);
  assign handshake       = instr_valid & dec_ready;

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    imem_req    = 1'b0;
    imem_addr   = 32'h0;
    capture     = 1'b0;
    clear_valid = 1'b0;
    set_kill    = 1'b0;
    clr_kill    = 1'b0;
    if (!rst) begin
      state_next = BOOT;
      pc_next    = RESET_VEC;
    end else begin
      case (state)
        BOOT: begin
          pc_next    = RESET_VEC;
          state_next = REQ;
        end
        REQ, WAIT: begin
          imem_req  = 1'b1;
          imem_addr = pc;
          // A redirect in REQ restarts at once; in WAIT it only restarts once the bus answers.
          if (redirect && (imem_ack || state == REQ)) begin
            pc_next     = redirect_target;
            state_next  = REQ;
            clr_kill    = 1'b1;
            clear_valid = 1'b1;
          end else if (imem_ack && kill) begin
            pc_next    = kill_target;
            state_next = REQ;
            clr_kill   = 1'b1;
          end else if (imem_ack) begin
            capture    = 1'b1;
            pc_next    = pc + 32'd4;
            state_next = HOLD;
          end else begin
            set_kill   = redirect;
            state_next = WAIT;
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_next     = redirect_target;
            clear_valid = 1'b1;
            state_next  = REQ;
          end else if (handshake) begin
            clear_valid = 1'b1;
            state_next  = REQ;
          end
        end
        default: state_next = BOOT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= BOOT;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      instr_valid <= 1'b0;
      fetch_cnt   <= 32'h0;
      kill        <= 1'b0;
      kill_target <= 32'h0;
    end else begin
      state <= state_next;
      if (capture) begin
        instr       <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (clear_valid) begin
        instr_valid <= 1'b0;
      end
      // A handshake counts even when a redirect discards the rest of the stream.
      if (state == HOLD && handshake)
        fetch_cnt <= fetch_cnt + 32'd1;
      if (set_kill) begin
        kill        <= 1'b1;
        kill_target <= redirect_target;
      end else if (clr_kill) begin
        kill <= 1'b0;
      end
    end
  end

`ifdef TRAP_EN_EN
  always_ff @(posedge clk) begin
    if (!rst)
      trap_epc <= 32'h0;
    else if (trap && state != BOOT)
      trap_epc <= pc;
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
// Directed bench for fetch_sequencer with a scoreboard of fetched words; covers the trap path when built with TRAP_EN_EN.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        dec_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] fetch_cnt;
`ifdef TRAP_EN_EN
  logic        trap_drive;
  logic [31:0] trap_epc;
`endif

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] addr;
  } sb_t;

  sb_t         sb[$];
  int          tests = 0;
  int          failed = 0;
  logic [31:0] exp_cnt = 32'h0;
  logic [31:0] next_a;

  fetch_sequencer #(
    .RESET_VEC(RESET_VEC),
    .TRAP_VEC (TRAP_VEC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_next    (pc_next),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .instr_valid(instr_valid),
    .dec_ready  (dec_ready),
    .br_taken   (br_taken),
    .br_target  (br_target),
`ifdef TRAP_EN_EN
    .trap       (trap_drive),
    .trap_epc   (trap_epc),
`endif
    .fetch_cnt  (fetch_cnt)
  );

  always #5 clk = ~clk;

  // External PC register that the sequencer steers through pc_next.
  always @(posedge clk) pc <= pc_next;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic br,
                               input logic [31:0] tgt, input logic ready);
    imem_ack   = ack;
    imem_rdata = rdata;
    br_taken   = br;
    br_target  = tgt;
    dec_ready  = ready;
    #2;
  endtask

  // Scoreboard pop on every decode handshake, then advance one clock.
  task automatic tick();
    sb_t e;
    if (rst && instr_valid && dec_ready) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_accept", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        checkOutput("sb_instr", instr, e.word);
        checkOutput("sb_instr_pc", instr_pc, e.addr);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input logic [31:0] a, input int waits, input int holds,
                           input logic br_last, input logic [31:0] tgt);
    logic [31:0] a4;
    logic [31:0] last_next;
    a4        = a + 32'd4;
    last_next = br_last ? (tgt & 32'hFFFF_FFFC) : a4;
    applyStimulus(waits == 0, mem_word(a), 1'b0, 32'h0, 1'b0);
    checkOutput("req_valid_low", 32'(instr_valid), 32'd0);
    checkOutput("req_imem_req", 32'(imem_req), 32'd1);
    checkOutput("req_addr", imem_addr, a);
    checkOutput("req_fetch_cnt", fetch_cnt, exp_cnt);
    if (waits == 0) begin
      checkOutput("req_ack_pc_next", pc_next, a4);
      sb.push_back('{word: mem_word(a), addr: a});
    end
    tick();
    if (waits > 0) begin
      for (int i = 1; i < waits; i++) begin
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        checkOutput("wait_addr", imem_addr, a);
        checkOutput("wait_pc_next", pc_next, a);
        tick();
      end
      applyStimulus(1'b1, mem_word(a), 1'b0, 32'h0, 1'b0);
      checkOutput("ack_addr", imem_addr, a);
      checkOutput("ack_pc_next", pc_next, a4);
      sb.push_back('{word: mem_word(a), addr: a});
      tick();
    end
    for (int i = 0; i < holds; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
      checkOutput("hold_valid", 32'(instr_valid), 32'd1);
      checkOutput("hold_imem_req", 32'(imem_req), 32'd0);
      checkOutput("hold_instr", instr, mem_word(a));
      checkOutput("hold_instr_pc", instr_pc, a);
      checkOutput("hold_fetch_cnt", fetch_cnt, exp_cnt);
      tick();
    end
    applyStimulus(1'b0, 32'h0, br_last, tgt, 1'b1);
    checkOutput("accept_valid", 32'(instr_valid), 32'd1);
    checkOutput("accept_imem_req", 32'(imem_req), 32'd0);
    checkOutput("accept_pc_next", pc_next, last_next);
    tick();
    exp_cnt = exp_cnt + 32'd1;
  endtask

  initial begin
    rst = 1'b0;
`ifdef TRAP_EN_EN
    trap_drive = 1'b0;
`endif
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("rst_pc_next", pc_next, RESET_VEC);
    checkOutput("rst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_valid", 32'(instr_valid), 32'd0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_instr_pc", instr_pc, 32'h0);
    checkOutput("rst_fetch_cnt", fetch_cnt, 32'h0);
`ifdef TRAP_EN_EN
    checkOutput("rst_trap_epc", trap_epc, 32'h0);
`endif

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("boot_pc_next", pc_next, RESET_VEC);
    checkOutput("boot_imem_req", 32'(imem_req), 32'd0);
    tick();

    fetch_one(32'h0, 1, 0, 1'b0, 32'h0);
    fetch_one(32'h4, 1, 0, 1'b0, 32'h0);
    fetch_one(32'h8, 1, 0, 1'b0, 32'h0);
    fetch_one(32'hC, 1, 5, 1'b0, 32'h0);

    // Branch during WAIT at 0x10, acked two cycles later: data must be dropped.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("kill_req_addr", imem_addr, 32'h10);
    checkOutput("kill_fetch_cnt", fetch_cnt, 32'd4);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h203, 1'b0);
    checkOutput("kill_br_req", 32'(imem_req), 32'd1);
    checkOutput("kill_br_addr", imem_addr, 32'h10);
    checkOutput("kill_br_pc_next", pc_next, 32'h10);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("kill_hold_req", 32'(imem_req), 32'd1);
    checkOutput("kill_hold_addr", imem_addr, 32'h10);
    tick();
    applyStimulus(1'b1, mem_word(32'h10), 1'b0, 32'h0, 1'b0);
    checkOutput("kill_ack_addr", imem_addr, 32'h10);
    checkOutput("kill_ack_pc_next", pc_next, 32'h200);
    tick();
    fetch_one(32'h200, 1, 0, 1'b1, 32'h33);

    // Second branch while a kill is pending overwrites the latched target.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("rekill_req_addr", imem_addr, 32'h30);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h500, 1'b0);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h42, 1'b0);
    checkOutput("rekill_pc_next", pc_next, 32'h30);
    tick();
    applyStimulus(1'b1, mem_word(32'h30), 1'b0, 32'h0, 1'b0);
    checkOutput("rekill_ack_pc_next", pc_next, 32'h40);
    tick();

`ifdef TRAP_EN_EN
    trap_drive = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h80, 1'b0);
    checkOutput("trap_addr", imem_addr, 32'h40);
    checkOutput("trap_pc_next", pc_next, TRAP_VEC);
    tick();
    trap_drive = 1'b0;
    checkOutput("trap_epc", trap_epc, 32'h40);
    next_a = TRAP_VEC;
`else
    next_a = 32'h40;
`endif

    // Branch coinciding with the ack in WAIT.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("samecyc_req_addr", imem_addr, next_a);
    tick();
    applyStimulus(1'b1, mem_word(next_a), 1'b1, 32'h5B, 1'b0);
    checkOutput("samecyc_pc_next", pc_next, 32'h58);
    tick();
    fetch_one(32'h58, 1, 0, 1'b1, 32'hFFFF_FFFF);
    fetch_one(32'hFFFF_FFFC, 2, 0, 1'b0, 32'h0);
    fetch_one(32'h0, 0, 0, 1'b0, 32'h0);

    // Branch taken in REQ redirects immediately.
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h61, 1'b0);
    checkOutput("reqbr_addr", imem_addr, 32'h4);
    checkOutput("reqbr_pc_next", pc_next, 32'h60);
    tick();
    fetch_one(32'h60, 1, 0, 1'b0, 32'h0);

    // Reset in WAIT with an ack arriving during and just after reset.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("midrst_req_addr", imem_addr, 32'h64);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, mem_word(32'h64), 1'b0, 32'h0, 1'b0);
    checkOutput("midrst_imem_req", 32'(imem_req), 32'd0);
    checkOutput("midrst_pc_next", pc_next, RESET_VEC);
    tick();
    applyStimulus(1'b1, mem_word(32'h64), 1'b0, 32'h0, 1'b0);
    tick();
    rst = 1'b1;
    exp_cnt = 32'h0;
    applyStimulus(1'b1, mem_word(32'h64), 1'b1, 32'h300, 1'b0);
    checkOutput("late_ack_pc_next", pc_next, RESET_VEC);
    checkOutput("late_ack_imem_req", 32'(imem_req), 32'd0);
    checkOutput("late_ack_valid", 32'(instr_valid), 32'd0);
    checkOutput("late_ack_fetch_cnt", fetch_cnt, 32'h0);
    tick();
    fetch_one(RESET_VEC, 1, 0, 1'b0, 32'h0);

    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The module SHALL have parameter RESET_VEC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The module SHALL have parameter TRAP_VEC, default 32'h0000_0100, giving the trap redirect address (used only with TRAP_EN_EN).
REQ-003 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 pc  input  32  current PC from the external PC register.
REQ-006 pc_next  output  32  next PC, registered by the PC register every cycle.
REQ-007 imem_req  output  1  instruction fetch request.
REQ-008 imem_addr  output  32  fetch address.
REQ-009 imem_ack  input  1  fetch done; imem_rdata valid this cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 instr  output  32  instruction to decode.
REQ-012 instr_pc  output  32  address of instr.
REQ-013 instr_valid  output  1  instr/instr_pc valid.
REQ-014 dec_ready  input  1  decode accepts instr this cycle.
REQ-015 br_taken  input  1  branch/jump redirect strobe.
REQ-016 br_target  input  32  redirect address.
REQ-017 fetch_cnt  output  32  count of instructions accepted by decode.
REQ-018 trap  input  1  trap redirect strobe (present only with TRAP_EN_EN).
REQ-019 trap_epc  output  32  PC held at trap (present only with TRAP_EN_EN).

Function
REQ-020 The FSM SHALL have states BOOT, REQ, WAIT, HOLD.
REQ-021 BOOT: pc_next=RESET_VEC, imem_req=0; next state REQ.
REQ-022 REQ: imem_req=1, imem_addr=pc, pc_next=pc; next state WAIT, or HOLD-equivalent capture if imem_ack=1 this cycle.
REQ-023 WAIT: imem_req=1, imem_addr=pc held stable until imem_ack; pc_next=pc.
REQ-024 On imem_ack with no pending kill, instr<=imem_rdata, instr_pc<=pc, instr_valid<=1 on the next edge (latency 1 cycle), pc_next=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC->0), next state HOLD.
REQ-025 HOLD: imem_req=0, pc_next=pc; when instr_valid&&dec_ready, instr_valid<=0, fetch_cnt<=fetch_cnt+1 (wraps), next state REQ.
REQ-026 Redirect target SHALL be br_target with bits [1:0] forced to 2'b00.
REQ-027 br_taken in REQ/HOLD: pc_next=target, instr_valid<=0, next state REQ; a same-cycle dec_ready handshake still increments fetch_cnt.
REQ-028 br_taken in WAIT without imem_ack: imem_req/imem_addr SHALL stay stable; kill flag and target latched; on the later ack the data SHALL be dropped, pc_next=latched target, next state REQ.
REQ-029 br_taken in WAIT with same-cycle imem_ack: data dropped, pc_next=target, next state REQ.
REQ-030 A second br_taken while kill pending SHALL overwrite the latched target.
REQ-031 br_taken in BOOT SHALL be ignored.

Reset
REQ-032 While rst=0: state BOOT, instr_valid=0, imem_req=0, instr=0, instr_pc=0, imem_addr=0, fetch_cnt=0, kill flag=0, trap_epc=0, pc_next=RESET_VEC.
REQ-033 rst asserted mid-fetch SHALL abandon the request; a late imem_ack after reset SHALL be ignored until state REQ.

Configuration
REQ-034 Macro TRAP_EN_EN defined: trap/trap_epc ports exist; trap behaves as br_taken with target TRAP_VEC, trap_epc<=pc, trap wins over same-cycle br_taken.
REQ-035 TRAP_EN_EN undefined: trap/trap_epc ports and logic SHALL be absent; behaviour otherwise identical.

Verification
REQ-036 Reset release, RESET_VEC=0, ack 1 cycle after req, dec_ready=1 -> imem_addr 0,4,8; fetch_cnt=3 after third accept.
REQ-037 dec_ready=0 for 5 cycles in HOLD -> instr_valid held 1, instr/instr_pc stable, imem_req=0, fetch_cnt unchanged.
REQ-038 In WAIT at pc=0x10, br_taken with br_target=0x203, ack 2 cycles later -> req/addr 0x10 stable, data dropped, next imem_addr=0x200, instr_valid never 1 for 0x10.
REQ-039 pc=0xFFFF_FFFC fetched and accepted -> pc_next=0x0000_0000.
REQ-040 TRAP_EN_EN: trap and br_taken(0x80) same cycle at pc=0x40 -> next imem_addr=0x100, trap_epc=0x40.
REQ-041 rst low during WAIT, ack arrives during reset -> after release instr_valid=0, first imem_addr=RESET_VEC.
